// File: rtl/irq_ctrl_if.sv
// irq_ctrl register window bus.
// Master drives strobes; slave returns read data.
interface irq_ctrl_if;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;

   modport master (
      output reg_we,
      output reg_addr,
      output reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_we,
      input  reg_addr,
      input  reg_wdata,
      output reg_rdata
   );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: collects device lines, picks the lowest
// unmasked pending index, pulses the core irq line.
module irq_ctrl #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_lines,
   input  logic             core_irq_en,
   output logic             irq_out,
   irq_ctrl_if.slave        bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRE,
      S_WAIT,
      S_SERV
   } state_e;

   state_e state_q, state_d;

   logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] edg_q, edg_d;
   logic [N_SRC-1:0] elig, win_oh, rise;
   logic [N_SRC-1:0] w1c, clr_win, wdat;
   logic [3:0]       win_id;
   logic [3:0]       claim_q, claim_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             irq_q, irq_d;
   logic             wr_pend, wr_mask;
   logic             wr_edge, eoi;
   logic [15:0]      rdata;
   logic             unused_wdata;

   assign wdat         = bus.reg_wdata[N_SRC-1:0];
   assign unused_wdata = ^bus.reg_wdata[15:N_SRC];

   // Decode the write strobe into per-register enables
   always_comb begin
      wr_pend = 1'b0;
      wr_mask = 1'b0;
      wr_edge = 1'b0;
      eoi     = 1'b0;
      unique case (1'b1)
         bus.reg_addr == 2'd0: wr_pend = bus.reg_we;
         bus.reg_addr == 2'd1: wr_mask = bus.reg_we;
         bus.reg_addr == 2'd2: wr_edge = bus.reg_we;
         bus.reg_addr == 2'd3: eoi     = bus.reg_we;
      endcase
   end

   // Read mux; unused upper bits stay zero
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         bus.reg_addr == 2'd0: rdata[N_SRC-1:0] = pend_q;
         bus.reg_addr == 2'd1: rdata[N_SRC-1:0] = mask_q;
         bus.reg_addr == 2'd2: rdata[N_SRC-1:0] = edg_q;
         bus.reg_addr == 2'd3:
            rdata = {busy_q, 11'b0, claim_q};
      endcase
   end

   assign bus.reg_rdata = rdata;

   // Arbitration runs on registered state only, so a
   // same-cycle write never changes the current winner
   assign elig   = pend_q & ~mask_q;
   assign win_oh = elig & (-elig);
   assign rise   = sync2_q & ~sync3_q;
   assign w1c    = wr_pend ? wdat : '0;

   // Encode the lowest eligible index
   always_comb begin
      win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) win_id = 4'(i);
      end
   end

   // Delivery FSM: claim, pulse, await ack, await EOI
   always_comb begin
      state_d = state_q;
      claim_d = claim_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      irq_d   = 1'b0;
      clr_win = '0;
      unique case (state_q)
         S_IDLE: begin
            if (|elig && core_irq_en) begin
               state_d = S_FIRE;
               claim_d = win_id;
               busy_d  = 1'b1;
               irq_d   = 1'b1;
               clr_win = edg_q & win_oh;
            end
         end
         S_FIRE: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            if (!core_irq_en) begin
               state_d = S_SERV;
            end else if (cnt_q == 4'd7) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SERV: begin
            if (eoi) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               claim_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Edge bits: a new rising edge beats W1C and claim.
   // Level bits track the synchronized line.
   always_comb begin
      pend_d = (edg_q & ((pend_q & ~w1c & ~clr_win) | rise))
             | (~edg_q & sync2_q);
      mask_d = wr_mask ? wdat : mask_q;
      edg_d  = wr_edge ? wdat : edg_q;
   end

   // Two-flop synchronizer plus previous level for edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= irq_lines;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Software-visible registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
         mask_q <= '1;
         edg_q  <= '0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         edg_q  <= edg_d;
      end
   end

   // FSM state and delivery bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         claim_q <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         claim_q <= claim_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         irq_q   <= irq_d;
      end
   end

   assign irq_out = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, directed
// corner sequences, random delivery vs a priority model.
module tb_irq_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_lines;
   logic         core_irq_en;
   logic         irq_out;

   irq_ctrl_if bus ();

   irq_ctrl #(.N_SRC(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_lines  (irq_lines),
      .core_irq_en(core_irq_en),
      .irq_out    (irq_out),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [10];
   logic [15:0] rv;
   bit          ok;
   int          cnt;
   logic [15:0] regm [4];
   int          q [$];

   task automatic chk(input string nm,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a,
                     output logic [15:0] d);
      bus.reg_addr = a;
      #1;
      d = bus.reg_rdata;
   endtask

   task automatic rdchk(input string nm,
                        input logic [1:0] a,
                        input logic [15:0] exp);
      logic [15:0] d;
      rd(a, d);
      chk(nm, d, exp);
   endtask

   task automatic wr(input logic [1:0] a,
                     input logic [15:0] d);
      bus.reg_we    = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      tick();
      bus.reg_we    = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq_lines = m;
      tick();
      irq_lines = '0;
   endtask

   task automatic wait_irq(input int max, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (irq_out) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_irq(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (irq_out) c++;
      end
   endtask

   // Core acknowledges, then the handler writes EOI
   task automatic handle();
      core_irq_en = 1'b0;
      tick();
      tick();
      wr(2'd3, 16'h0000);
      core_irq_en = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 2'd1, 16'h0000, 16'h00FF};
      tbl[1] = '{1'b0, 2'd2, 16'h0000, 16'h0000};
      tbl[2] = '{1'b0, 2'd0, 16'h0000, 16'h0000};
      tbl[3] = '{1'b0, 2'd3, 16'h0000, 16'h0000};
      tbl[4] = '{1'b1, 2'd1, 16'h1234, 16'h0034};
      tbl[5] = '{1'b1, 2'd2, 16'hFFA5, 16'h00A5};
      tbl[6] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000};
      tbl[7] = '{1'b1, 2'd3, 16'hFFFF, 16'h0000};
      tbl[8] = '{1'b1, 2'd1, 16'hFF00, 16'h0000};
      tbl[9] = '{1'b1, 2'd2, 16'h0000, 16'h0000};

      rst           = 1'b0;
      irq_lines     = '0;
      core_irq_en   = 1'b0;
      bus.reg_we    = 1'b0;
      bus.reg_addr  = 2'd0;
      bus.reg_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_irq_out", {15'b0, irq_out}, 16'h0);
      rst = 1'b1;
      tick();

      // Register table
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
         rd(tbl[i].addr, rv);
         chk($sformatf("table[%0d]", i), rv, tbl[i].exp);
      end

      // Single edge source, exact pulse timing
      wr(2'd1, 16'h0000);
      wr(2'd2, 16'h0001);
      core_irq_en = 1'b1;
      pulse(8'h01);
      tick();
      chk("s1_t1", {15'b0, irq_out}, 16'h0);
      tick();
      chk("s1_t2", {15'b0, irq_out}, 16'h0);
      tick();
      chk("s1_fire", {15'b0, irq_out}, 16'h1);
      rdchk("s1_claim", 2'd3, 16'h8000);
      rdchk("s1_pend", 2'd0, 16'h0000);
      core_irq_en = 1'b0;
      tick();
      chk("s1_one_cycle", {15'b0, irq_out}, 16'h0);
      tick();
      wr(2'd3, 16'h0000);
      rdchk("s1_eoi", 2'd3, 16'h0000);
      core_irq_en = 1'b1;

      // Two simultaneous edges, priority order
      wr(2'd2, 16'h00FF);
      pulse(8'h24);
      wait_irq(8, ok);
      chk("s2_irq_a", {15'b0, ok}, 16'h1);
      rdchk("s2_claim_a", 2'd3, 16'h8002);
      handle();
      wait_irq(4, ok);
      chk("s2_irq_b", {15'b0, ok}, 16'h1);
      rdchk("s2_claim_b", 2'd3, 16'h8005);
      handle();
      rdchk("s2_pend", 2'd0, 16'h0000);

      // Masked level source, then unmask
      wr(2'd2, 16'h0000);
      wr(2'd1, 16'h00FF);
      irq_lines = 8'h08;
      count_irq(6, cnt);
      chk("s3_masked", 16'(cnt), 16'h0);
      rdchk("s3_pend", 2'd0, 16'h0008);
      wr(2'd1, 16'h00F7);
      wait_irq(2, ok);
      chk("s3_irq", {15'b0, ok}, 16'h1);
      rdchk("s3_claim", 2'd3, 16'h8003);
      irq_lines   = '0;
      core_irq_en = 1'b0;
      tick();
      tick();
      wr(2'd1, 16'h00FF);
      wr(2'd3, 16'h0000);
      core_irq_en = 1'b1;
      count_irq(5, cnt);
      chk("s3_quiet", 16'(cnt), 16'h0);
      rdchk("s3_pend_low", 2'd0, 16'h0000);

      // Re-pulse during service is queued again
      wr(2'd2, 16'h00FF);
      wr(2'd1, 16'h0000);
      pulse(8'h02);
      wait_irq(8, ok);
      chk("s4_irq_a", {15'b0, ok}, 16'h1);
      rdchk("s4_claim_a", 2'd3, 16'h8001);
      core_irq_en = 1'b0;
      tick();
      tick();
      pulse(8'h02);
      tick();
      tick();
      tick();
      rdchk("s4_pend", 2'd0, 16'h0002);
      wr(2'd3, 16'h0000);
      core_irq_en = 1'b1;
      wait_irq(4, ok);
      chk("s4_irq_b", {15'b0, ok}, 16'h1);
      rdchk("s4_claim_b", 2'd3, 16'h8001);
      handle();

      // Ack timeout with core_irq_en held high
      pulse(8'h10);
      wait_irq(8, ok);
      chk("s5_irq", {15'b0, ok}, 16'h1);
      rdchk("s5_busy", 2'd3, 16'h8004);
      repeat (8) tick();
      rd(2'd3, rv);
      chk("s5_busy_late", {15'b0, rv[15]}, 16'h1);
      tick();
      rd(2'd3, rv);
      chk("s5_timeout", {15'b0, rv[15]}, 16'h0);
      count_irq(12, cnt);
      chk("s5_no_repeat", 16'(cnt), 16'h0);
      rdchk("s5_pend", 2'd0, 16'h0000);

      // Asynchronous reset while in service
      pulse(8'h01);
      wait_irq(8, ok);
      chk("s6_irq", {15'b0, ok}, 16'h1);
      core_irq_en = 1'b0;
      tick();
      tick();
      pulse(8'h40);
      tick();
      tick();
      rdchk("s6_pend_pre", 2'd0, 16'h0040);
      rst = 1'b0;
      #1;
      chk("s6_irq_out", {15'b0, irq_out}, 16'h0);
      rdchk("s6_claim", 2'd3, 16'h0000);
      rdchk("s6_pend", 2'd0, 16'h0000);
      rdchk("s6_mask", 2'd1, 16'h00FF);
      tick();
      rst = 1'b1;
      tick();

      // Random MASK/EDGE traffic against a register model
      regm[1] = 16'h00FF;
      regm[2] = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         automatic int          a = int'($urandom_range(1, 2));
         automatic logic [15:0] d = 16'($urandom);
         wr(2'(a), d);
         regm[a] = d & 16'h00FF;
         rdchk("rnd_mask", 2'd1, regm[1]);
         rdchk("rnd_edge", 2'd2, regm[2]);
      end

      // Random edge bursts: delivery in ascending index
      // order of the unmasked set, masked bits left pending
      wr(2'd2, 16'h00FF);
      core_irq_en = 1'b1;
      for (int it = 0; it < 20; it++) begin
         automatic logic [7:0] m = 8'($urandom_range(0, 255));
         automatic logic [7:0] s = 8'($urandom_range(1, 255));
         wr(2'd0, 16'h00FF);
         wr(2'd1, {8'h00, m});
         pulse(s);
         q.delete();
         for (int b = 0; b < N; b++)
            if (s[b] && !m[b]) q.push_back(b);
         while (q.size() > 0) begin
            automatic int id = q.pop_front();
            wait_irq(10, ok);
            chk("rnd_irq", {15'b0, ok}, 16'h1);
            rdchk("rnd_claim", 2'd3, 16'h8000 | 16'(id));
            handle();
         end
         count_irq(8, cnt);
         chk("rnd_quiet", 16'(cnt), 16'h0);
         rdchk("rnd_pend", 2'd0, {8'h00, s & m});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that is the source side of the core's single interrupt line: it collects up to N_SRC device interrupt lines, synchronizes, latches and masks them, selects the highest-priority request, and delivers it to the core's special-register unit as a one-cycle `irq_out` pulse. It sits between the peripherals and the core's `irq_in`/`irq_en` pair. It exposes a small register window so the IRQ handler can read the claimed source and signal end-of-interrupt (EOI).

## Interface
- N_SRC, 8, number of interrupt sources (1..15); index 0 is highest priority.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_lines  in  N_SRC  raw device requests, asynchronous to clk.
- core_irq_en  in  1  core's interrupt-enable status (`irq_en` from the special-register unit).
- irq_out  out  1  to core `irq_in`; registered one-cycle pulse.
- reg_we  in  1  register write strobe.
- reg_addr  in  2  register select.
- reg_wdata  in  16  write data.
- reg_rdata  out  16  read data, combinational from `reg_addr`.

## Operation
- Registers; bits at and above N_SRC read 0 and ignore writes:
  - 0 PENDING: read pending bits; write-1-to-clear for edge sources, no effect on level sources.
  - 1 MASK: R/W; bit=1 blocks the source. Reset value is all ones (N_SRC bits).
  - 2 EDGE: R/W; bit=1 edge-triggered (rising), 0 level-high. Reset 0.
  - 3 CLAIM: read returns {busy at bit 15, 11'b0, claim_id[3:0]}. A write of any value is EOI. Reads have no side effects.
- Each line passes a 2-flop synchronizer. Edge mode: a rising edge of the synchronized signal sets the pending bit, which holds until W1C or claim. Level mode: the pending bit equals the synchronized level.
- Eligible set = PENDING & ~MASK. The winner is the lowest eligible index.
- FSM states:
  - IDLE: if the eligible set is non-empty and core_irq_en=1, go to FIRE, latch claim_id = winner, and clear the winner's pending bit if it is edge-mode.
  - FIRE: irq_out=1 for exactly this cycle, busy=1; go to WAIT_ACK.
  - WAIT_ACK: wait for core_irq_en=0, then go to SERVICE. If 8 cycles pass without it, return to IDLE, clear busy, and do not re-pend the source (a lost request).
  - SERVICE: a CLAIM write (EOI) goes to IDLE and clears busy. Other register writes act normally.
- EOI outside SERVICE is ignored.
- After EOI, the next delivery requires core_irq_en=1 again. The core re-enables interrupts itself, so there is no nesting.
- Precedence rules:
  - An edge set and a W1C on the same bit in the same cycle: set wins.
  - An edge set on the winner in the same cycle as its claim: the pending bit stays set, so the request is queued again.
  - Winner selection uses register values before any same-cycle write.
- Reset mid-operation: return to IDLE immediately. Outputs reset to irq_out=0, busy=0, claim_id=0, PENDING=0, synchronizers=0.

## Timing
- Source line high at sampling edge t: synchronized level at t+2; pending visible t+3; FIRE (irq_out high) during cycle t+4, provided the FSM is in IDLE and core_irq_en=1.
- irq_out is never high for two consecutive cycles.
- The minimum spacing between two irq_out pulses is 4 cycles (FIRE, WAIT_ACK, SERVICE+EOI, IDLE).
- reg_rdata is combinational. Writes take effect at the next edge.

## Test plan
- Reset, MASK=0x00, EDGE=0x01; pulse line0 for 1 cycle → irq_out high exactly cycle t+4 for 1 cycle; CLAIM reads 0x8000; PENDING bit0=0; core_irq_en drops → SERVICE; EOI write → CLAIM reads 0x0000.
- Lines 2 and 5 rise together, both edge, unmasked → first claim id 2; after EOI and core_irq_en=1, second pulse with id 5.
- MASK=0xFF, level line3 high → no irq_out, PENDING reads 0x08; write MASK=0xF7 → irq_out within 2 cycles, claim id 3.
- Edge line1 re-pulses during SERVICE for id 1 → PENDING bit1=1; after EOI, irq_out fires again with id 1.
- Hold core_irq_en=1 after FIRE → WAIT_ACK times out after 8 cycles, busy=0, no second pulse while nothing is pending.
- Assert rst low during SERVICE → irq_out=0, CLAIM=0x0000, PENDING=0x00, MASK=0xFF immediately, without waiting for a clock edge.
